workspace_temp: RTL and testbench
=================================

// Module: workspace_temp
// PURPOSE
//  - Registered two-input logic evaluator: c = F(a,b), where F is a 4-entry truth table set by parameter.
//  - Scratch/sandbox block for small gate-level experiments.
//  - Sits between single-bit control inputs and a single registered status output.
// PARAMETERS
//  - TRUTH_TABLE  4'b1000  F(a,b) = TRUTH_TABLE[{a,b}]; default is AND (bit3 = a&b)
//  - PIPE_STAGES  1        output register stages, legal range 1..4; elaboration error outside this range
// PORTS
//  - clk  input  1  rising-edge clock, single clock domain
//  - rst  input  1  reset, synchronous, active-high
//  - a    input  1  operand A (index MSB)
//  - b    input  1  operand B (index LSB)
//  - c    output 1  registered result F(a,b)
//  - Declaration order is clk, a, b, c, rst, so positional hookups (clk,a,b,c) remain valid.
//  - One clock; reset is synchronous and active-high.
// BEHAVIOUR
//  - Combinational f = TRUTH_TABLE[{a,b}]:
//      {a,b}=00 -> bit0, 01 -> bit1, 10 -> bit2, 11 -> bit3.
//  - f passes through PIPE_STAGES flops; c is the last stage.
//  - Latency is PIPE_STAGES cycles from a/b sampled at a rising edge to c.
//  - No combinational path from a/b to c.
//  - rst=1 at a rising edge clears every pipeline flop to 0, so c=0 from the next edge.
//  - Reset has priority over the data update on the same edge.
//  - After rst deasserts, the first valid c appears PIPE_STAGES edges later.
//  - Until then c holds 0, and the flushed stages are 0, not stale data.
//  - Reset mid-operation discards all in-flight results; no partial shifting.
//  - a/b changing between edges has no effect; only the value present at the edge is sampled.
//  - X on a/b propagates as X in simulation; no X-masking logic.
//  - No handshake; every cycle is a new sample.
// CONFIGURATION
//  - Macro WORKSPACE_TEMP_SYNC_EN.
//  - Defined: a and b each pass through a 2-flop synchronizer (reset to 0) before truth-table lookup.
//    - Total latency = PIPE_STAGES+2.
//    - Reset clears the synchronizer flops as well.
//  - Undefined: a/b feed the lookup directly; latency = PIPE_STAGES.
// STRUCTURE
//  - Package workspace_temp_pkg holds:
//    - truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, TT_NAND=4'b0111, TT_NOR=4'b0001;
//    - localparam MAX_PIPE=4.
//  - Sub-module ws_pipe_reg: parameterised N-deep 1-bit shift register with sync active-high clear.
//    - Used for both the output pipeline and the synchronizers.
// TESTING
//  - All tests use the defaults (AND, PIPE_STAGES=1) unless noted; clk period 10ns.
//  - Reset: rst=1 for 2 edges with a=1,b=1 -> c=0 throughout; release rst -> c=1 one edge later.
//  - Truth-table sweep: apply ab=00,01,10,11 on successive edges -> c=0,0,0,1, each one edge after its sample.
//    - Repeat with TRUTH_TABLE=TT_XOR -> c=0,1,1,0.
//  - Latency: PIPE_STAGES=3, pulse a=b=1 for one cycle -> c=1 for exactly one cycle, 3 edges later.
//  - Mid-operation reset: PIPE_STAGES=3, a=b=1 held, assert rst for 1 edge -> c=0 for 3 edges after release, then 1.
//  - Between-edge glitch: toggle a between edges (returning before the edge) -> c unchanged.
//  - WORKSPACE_TEMP_SYNC_EN defined: ab 00->11 -> c rises exactly PIPE_STAGES+2 edges later.

Source files
------------

// File: rtl/workspace_temp_pkg.sv
// Shared constants for the workspace_temp evaluator: truth-table presets and pipeline depth limit.
package workspace_temp_pkg;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;

  localparam int unsigned MAX_PIPE = 4;

  // a is the index MSB, b the LSB
  function automatic logic tt_lookup(input logic [3:0] tt, input logic a, input logic b);
    logic [1:0] idx;
    idx = {a, b};
    return tt[idx];
  endfunction

endpackage

// File: rtl/ws_pipe_reg.sv
// N-deep 1-bit shift register with synchronous active-high clear; q is the last stage.
module ws_pipe_reg #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/workspace_temp.sv
// Registered two-input truth-table evaluator c = TRUTH_TABLE[{a,b}] with PIPE_STAGES output flops.
// Define WORKSPACE_TEMP_SYNC_EN to add a 2-flop synchronizer on each of a and b.
module workspace_temp
  import workspace_temp_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE = TT_AND,
  parameter int unsigned PIPE_STAGES = 1
) (
  input  logic clk,
  input  logic a,
  input  logic b,
  output logic c,
  input  logic rst
);

  if (PIPE_STAGES < 1 || PIPE_STAGES > MAX_PIPE) begin : g_bad_pipe
    $error("workspace_temp: PIPE_STAGES=%0d outside legal range 1..%0d", PIPE_STAGES, MAX_PIPE);
  end

  logic a_in;
  logic b_in;
  logic f;

`ifdef WORKSPACE_TEMP_SYNC_EN
  ws_pipe_reg #(.DEPTH(2)) u_sync_a (
    .clk (clk),
    .rst (rst),
    .d   (a),
    .q   (a_in)
  );

  ws_pipe_reg #(.DEPTH(2)) u_sync_b (
    .clk (clk),
    .rst (rst),
    .d   (b),
    .q   (b_in)
  );
`else
  assign a_in = a;
  assign b_in = b;
`endif

  always_comb begin
    f = tt_lookup(TRUTH_TABLE, a_in, b_in);
  end

  ws_pipe_reg #(.DEPTH(PIPE_STAGES)) u_out_pipe (
    .clk (clk),
    .rst (rst),
    .d   (f),
    .q   (c)
  );

endmodule

// File: tb/tb_workspace_temp.sv
// Self-checking bench for workspace_temp: several parameterisations against an edge-history reference model.
module tb_workspace_temp;
  import workspace_temp_pkg::*;

`ifdef WORKSPACE_TEMP_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int MAX_EDGES = 2048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a   = 1'b0;
  logic b   = 1'b0;
  logic c_and1, c_xor1, c_and3, c_nor4;

  int checks   = 0;
  int failures = 0;

  // Sampled inputs per rising edge, indexed by edge number
  logic hist_a [MAX_EDGES];
  logic hist_b [MAX_EDGES];
  logic hist_r [MAX_EDGES];
  int   edge_n = 0;

  always #5 clk = ~clk;

  workspace_temp u_and1 (.clk(clk), .a(a), .b(b), .c(c_and1), .rst(rst));

  workspace_temp #(.TRUTH_TABLE(TT_XOR), .PIPE_STAGES(1)) u_xor1 (
    .clk(clk), .a(a), .b(b), .c(c_xor1), .rst(rst));

  workspace_temp #(.TRUTH_TABLE(TT_AND), .PIPE_STAGES(3)) u_and3 (
    .clk(clk), .a(a), .b(b), .c(c_and3), .rst(rst));

  workspace_temp #(.TRUTH_TABLE(TT_NOR), .PIPE_STAGES(4)) u_nor4 (
    .clk(clk), .a(a), .b(b), .c(c_nor4), .rst(rst));

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%b expected=%b", tag, edge_n, got, exp);
    end
  endtask

  // c after the latest edge reflects the sample taken lat edges ago, unless any
  // edge in that window (or before time zero) carried a reset.
  function automatic logic model_c(input logic [3:0] tt, input int lat);
    int n;
    logic [1:0] idx;
    n = edge_n - 1;
    for (int k = n - lat + 1; k <= n; k++) begin
      if (k < 0) return 1'b0;
      if (hist_r[k]) return 1'b0;
    end
    idx = {hist_a[n-lat+1], hist_b[n-lat+1]};
    return tt[idx];
  endfunction

  // Called at a falling edge: drive inputs, optionally glitch a, take one rising edge, check at the next falling edge.
  task automatic step(input logic na, input logic nb, input logic nrst, input bit glitch);
    a   = na;
    b   = nb;
    rst = nrst;
    if (glitch) begin
      #2 a = ~na;
      #1 a = na;
    end
    @(posedge clk);
    if (edge_n < MAX_EDGES) begin
      hist_a[edge_n] = a;
      hist_b[edge_n] = b;
      hist_r[edge_n] = rst;
      edge_n++;
    end
    @(negedge clk);
    check_bit("and_p1", c_and1, model_c(TT_AND, 1 + SYNC_LAT));
    check_bit("xor_p1", c_xor1, model_c(TT_XOR, 1 + SYNC_LAT));
    check_bit("and_p3", c_and3, model_c(TT_AND, 3 + SYNC_LAT));
    check_bit("nor_p4", c_nor4, model_c(TT_NOR, 4 + SYNC_LAT));
  endtask

  initial begin
    logic [1:0] ab;
    @(negedge clk);

    // Reset held two edges with a=b=1, then release
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Truth-table sweep 00,01,10,11
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      step(ab[1], ab[0], 1'b0, 1'b0);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Single-cycle pulse a=b=1
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

    // Mid-operation reset with a=b=1 held
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0);

    // Between-edge glitches on a
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      step(ab[1], ab[0], 1'b0, 1'b1);
    end

    // Randomised traffic with occasional resets and glitches
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout edge=%0d got=running expected=finished", edge_n);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
